// File: rtl/wdt_pkg.sv
// wdt_pkg: shared state encoding and register map for the watchdog bank and counter
package wdt_pkg;
  typedef enum logic [1:0] {IDLE, RUN, ARMED, RESET} wdt_state_e;
  localparam logic [11:0] WDT_LOAD_ADDR  = 12'h000;
  localparam logic [11:0] WDT_VALUE_ADDR = 12'h004;
  localparam logic [11:0] WDT_CTL_ADDR   = 12'h008;
  localparam logic [11:0] WDT_ICR_ADDR   = 12'h00C;
  localparam logic [11:0] WDT_TEST_ADDR  = 12'h418;
  localparam logic [11:0] WDT_LOCK_ADDR  = 12'hC00;
  localparam logic [31:0] WDT_UNLOCK_KEY = 32'h1ACC_E551;
endpackage

// File: rtl/wdt_counter.sv
// wdt_counter: watchdog down-counter with timeout event and second-timeout reset escalation
module wdt_counter
  import wdt_pkg::*;
#(
  parameter int          RST_CYCLES = 4,
  parameter logic [31:0] LOAD_RST   = 32'hFFFF_FFFF
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic        wr_en,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  input  logic        lock,
  input  logic        int_en,
  input  logic        resen,
  input  logic        stall,
  input  logic        dbg_halt,
  input  logic        test,
  input  logic        wr_en_icr,
  output logic [31:0] cnt_load,
  output logic [31:0] cnt_value,
  output logic        value_eq0,
  output logic        test_reset,
  output logic        wdt_rst
);
  localparam int RW = $clog2(RST_CYCLES + 1);
  wdt_state_e state, state_d;
  logic [31:0] load_d, value_d;
  logic eq0_d, trst_d, wrst_d, load_wr, tick, unused_paddr;
  logic [RW-1:0] rcnt, rcnt_d;
  assign unused_paddr = ^paddr[31:12];
  assign load_wr = wr_en && paddr[11:0] == WDT_LOAD_ADDR && !lock;
  assign tick = (state == RUN || state == ARMED) && !(stall && dbg_halt);
  always_comb begin
    state_d = state;
    load_d  = cnt_load;
    value_d = cnt_value;
    eq0_d   = 1'b0;
    trst_d  = test_reset;
    wrst_d  = wdt_rst;
    rcnt_d  = rcnt;
    if (state == IDLE) begin
      if (int_en) begin
        state_d = RUN;
        value_d = cnt_load;
      end
    end else if (state == RESET) begin
      if (rcnt == RW'(RST_CYCLES)) begin
        state_d = RUN;
        value_d = cnt_load;
        wrst_d  = 1'b0;
        rcnt_d  = '0;
      end else rcnt_d = rcnt + 1'b1;
    end else begin
      if (wr_en_icr) trst_d = 1'b0;
      if (wr_en_icr && state == ARMED) begin
        state_d = RUN;
        value_d = cnt_load;
      end else if (tick && !load_wr) begin
        if (cnt_value != 32'd0) value_d = cnt_value - 32'd1;
        else begin
          value_d = cnt_load;
          eq0_d   = 1'b1;
          if (state == RUN) state_d = ARMED;
          else if (resen && !test) begin
            state_d = RESET;
            wrst_d  = 1'b1;
            rcnt_d  = RW'(1);
          end else if (resen) trst_d = 1'b1;
        end
      end
    end
    // a load write overrides any reload chosen above but leaves the pending state alone
    if (load_wr) begin
      load_d  = pwdata;
      value_d = pwdata;
    end
  end
  always_ff @(posedge pclk) begin
    if (preset) begin
      state      <= IDLE;
      cnt_load   <= LOAD_RST;
      cnt_value  <= LOAD_RST;
      value_eq0  <= 1'b0;
      test_reset <= 1'b0;
      wdt_rst    <= 1'b0;
      rcnt       <= '0;
    end else begin
      state      <= state_d;
      cnt_load   <= load_d;
      cnt_value  <= value_d;
      value_eq0  <= eq0_d;
      test_reset <= trst_d;
      wdt_rst    <= wrst_d;
      rcnt       <= rcnt_d;
    end
  end
endmodule

// File: tb/tb_wdt_counter.sv
// tb_wdt_counter: scoreboard bench for the watchdog counter; observed tuple is {value,load,eq0,rst,test_reset}
module tb_wdt_counter;
  import wdt_pkg::*;
  logic pclk = 1'b0;
  logic preset, wr_en, lock, int_en, resen, stall, dbg_halt, test, wr_en_icr;
  logic [31:0] paddr, pwdata, cnt_load, cnt_value;
  logic value_eq0, test_reset, wdt_rst;
  typedef struct packed {
    logic [31:0] v;
    logic [31:0] l;
    logic e, r, t;
  } obs_t;
  obs_t q[$];
  obs_t got, exp_o;
  int n_run = 0, n_fail = 0;
  localparam logic [31:0] ONES = 32'hFFFF_FFFF;

  wdt_counter #(.RST_CYCLES(4), .LOAD_RST(ONES)) dut (
    .pclk(pclk), .preset(preset), .wr_en(wr_en), .paddr(paddr), .pwdata(pwdata),
    .lock(lock), .int_en(int_en), .resen(resen), .stall(stall), .dbg_halt(dbg_halt),
    .test(test), .wr_en_icr(wr_en_icr), .cnt_load(cnt_load), .cnt_value(cnt_value),
    .value_eq0(value_eq0), .test_reset(test_reset), .wdt_rst(wdt_rst)
  );

  always #5 pclk = ~pclk;
  assign got = {cnt_value, cnt_load, value_eq0, wdt_rst, test_reset};

  task step;
    @(posedge pclk);
    #1;
  endtask

  task push(input logic [31:0] v, input logic [31:0] l, input logic e, input logic r, input logic t);
    q.push_back(obs_t'({v, l, e, r, t}));
  endtask

  task idle_in;
    wr_en = 0; paddr = {20'd0, WDT_LOAD_ADDR}; pwdata = 0; lock = 0; int_en = 0; resen = 0;
    stall = 0; dbg_halt = 0; test = 0; wr_en_icr = 0; preset = 0;
  endtask

  task por;
    idle_in();
    preset = 1;
    step();
    step();
    preset = 0;
  endtask

  task test_por;
    por();
    push(ONES, ONES, 0, 0, 0);
    push(ONES, ONES, 0, 0, 0);
    exp_o = q.pop_front(); n_run++;
    if (got !== exp_o) begin n_fail++; $display("FAIL por: got %h want %h", got, exp_o); end
    lock = 1; wr_en = 1; pwdata = 32'h55;
    step();
    exp_o = q.pop_front(); n_run++;
    if (got !== exp_o) begin n_fail++; $display("FAIL por_locked_write: got %h want %h", got, exp_o); end
  endtask

  task test_timeout;
    por();
    push(5, 5, 0, 0, 0);
    for (int k = 5; k >= 0; k--) push(32'(k), 5, 0, 0, 0);
    push(5, 5, 1, 0, 0);
    push(4, 5, 0, 0, 0);
    for (int i = 0; i <= 8; i++) begin
      wr_en = (i == 0); pwdata = 5; int_en = (i >= 1);
      step();
      exp_o = q.pop_front(); n_run++;
      if (got !== exp_o) begin n_fail++; $display("FAIL timeout cyc %0d: got %h want %h", i, got, exp_o); end
    end
  endtask

  task test_escalate;
    por();
    push(3, 3, 0, 0, 0);
    for (int k = 3; k >= 0; k--) push(32'(k), 3, 0, 0, 0);
    push(3, 3, 1, 0, 0);
    for (int k = 2; k >= 0; k--) push(32'(k), 3, 0, 0, 0);
    push(3, 3, 1, 1, 0);
    for (int k = 0; k < 3; k++) push(3, 3, 0, 1, 0);
    push(3, 3, 0, 0, 0);
    push(2, 3, 0, 0, 0);
    for (int i = 0; i <= 14; i++) begin
      wr_en = (i == 0); pwdata = 3; int_en = (i >= 1); resen = 1;
      step();
      exp_o = q.pop_front(); n_run++;
      if (got !== exp_o) begin n_fail++; $display("FAIL escalate cyc %0d: got %h want %h", i, got, exp_o); end
    end
  endtask

  task test_icr;
    por();
    push(3, 3, 0, 0, 0);
    for (int k = 3; k >= 0; k--) push(32'(k), 3, 0, 0, 0);
    push(3, 3, 1, 0, 0);
    push(3, 3, 0, 0, 0);
    for (int k = 2; k >= 0; k--) push(32'(k), 3, 0, 0, 0);
    push(3, 3, 1, 0, 0);
    push(2, 3, 0, 0, 0);
    for (int i = 0; i <= 11; i++) begin
      wr_en = (i == 0); pwdata = 3; int_en = (i >= 1); resen = 1; wr_en_icr = (i == 6);
      step();
      exp_o = q.pop_front(); n_run++;
      if (got !== exp_o) begin n_fail++; $display("FAIL icr cyc %0d: got %h want %h", i, got, exp_o); end
    end
  endtask

  task test_testmode;
    por();
    push(2, 2, 0, 0, 0);
    for (int k = 2; k >= 0; k--) push(32'(k), 2, 0, 0, 0);
    push(2, 2, 1, 0, 0);
    push(1, 2, 0, 0, 0);
    push(0, 2, 0, 0, 0);
    push(2, 2, 1, 0, 1);
    push(1, 2, 0, 0, 1);
    push(0, 2, 0, 0, 1);
    push(2, 2, 1, 0, 1);
    push(2, 2, 0, 0, 0);
    push(1, 2, 0, 0, 0);
    for (int i = 0; i <= 12; i++) begin
      wr_en = (i == 0); pwdata = 2; int_en = (i >= 1); resen = 1; test = 1; wr_en_icr = (i == 11);
      step();
      exp_o = q.pop_front(); n_run++;
      if (got !== exp_o) begin n_fail++; $display("FAIL testmode cyc %0d: got %h want %h", i, got, exp_o); end
    end
  endtask

  task test_stall;
    por();
    for (int k = 0; k <= 11; k++) push(100, 100, 0, 0, 0);
    push(99, 100, 0, 0, 0);
    push(98, 100, 0, 0, 0);
    for (int i = 0; i <= 13; i++) begin
      wr_en = (i == 0); pwdata = 100; int_en = (i >= 1);
      stall = (i >= 2 && i <= 11); dbg_halt = (i >= 2);
      step();
      exp_o = q.pop_front(); n_run++;
      if (got !== exp_o) begin n_fail++; $display("FAIL stall cyc %0d: got %h want %h", i, got, exp_o); end
    end
  endtask

  task test_collision_lock;
    por();
    push(1, 1, 0, 0, 0);
    push(1, 1, 0, 0, 0);
    push(0, 1, 0, 0, 0);
    push(7, 7, 0, 0, 0);
    push(6, 7, 0, 0, 0);
    push(5, 7, 0, 0, 0);
    push(4, 7, 0, 0, 0);
    for (int i = 0; i <= 6; i++) begin
      wr_en = (i == 0 || i == 3 || i == 5);
      pwdata = (i == 5) ? 32'h55 : (i == 3) ? 32'd7 : 32'd1;
      lock = (i == 5); int_en = (i >= 1);
      step();
      exp_o = q.pop_front(); n_run++;
      if (got !== exp_o) begin n_fail++; $display("FAIL collision_lock cyc %0d: got %h want %h", i, got, exp_o); end
    end
  endtask

  task test_zero_load_preset;
    por();
    push(0, 0, 0, 0, 0);
    push(0, 0, 0, 0, 0);
    push(0, 0, 1, 0, 0);
    push(0, 0, 1, 1, 0);
    push(0, 0, 0, 1, 0);
    push(ONES, ONES, 0, 0, 0);
    push(ONES, ONES, 0, 0, 0);
    push(ONES - 1, ONES, 0, 0, 0);
    for (int i = 0; i <= 7; i++) begin
      wr_en = (i == 0); pwdata = 0; int_en = (i >= 1); resen = 1; preset = (i == 5);
      step();
      exp_o = q.pop_front(); n_run++;
      if (got !== exp_o) begin n_fail++; $display("FAIL zero_load_preset cyc %0d: got %h want %h", i, got, exp_o); end
    end
    preset = 0;
  endtask

  initial begin
    idle_in();
    test_por();
    test_timeout();
    test_escalate();
    test_icr();
    test_testmode();
    test_stall();
    test_collision_lock();
    test_zero_load_preset();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/wdt_counter.md
# wdt_counter

Watchdog down-counter core that consumes the control/status outputs of the WDT register bank and produces the count, load and timeout events that bank samples. It holds the load value, decrements once per enabled cycle, raises a one-cycle zero event on each timeout, and escalates a second unserviced timeout into a system reset pulse, or into a sticky test flag in test mode.

## Interface
- `RST_CYCLES`, 4: width of the `wdt_rst` pulse in `pclk` cycles, must be ≥1.
- `LOAD_RST`, 32'hFFFF_FFFF: reset value of `cnt_load` and `cnt_value`.
- `pclk`  in  1  bus/watchdog clock; all logic on its rising edge.
- `preset`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  APB write strobe, qualified.
- `paddr`  in  32  APB address; only `[11:0]` decoded.
- `pwdata`  in  32  APB write data.
- `lock`  in  1  register lock from the register bank.
- `int_en`  in  1  ctl[0]; starts the counter and is sticky in the bank.
- `resen`  in  1  ctl[1]; enables reset on second timeout.
- `stall`  in  1  stall-in-debug enable.
- `dbg_halt`  in  1  CPU debug-halt indication.
- `test`  in  1  test mode: suppresses `wdt_rst`.
- `wr_en_icr`  in  1  interrupt-clear write strobe from the bank.
- `cnt_load`  out  32  current load value.
- `cnt_value`  out  32  current count.
- `value_eq0`  out  1  one-cycle timeout event.
- `test_reset`  out  1  sticky "reset would have fired" flag in test mode.
- `wdt_rst`  out  1  watchdog reset request pulse.

## Operation
- States:
  - IDLE: `int_en`=0, no decrement.
  - RUN: counting, no pending timeout.
  - ARMED: one timeout pending.
  - RESET: `wdt_rst` held high.
- Transitions out of IDLE: when `int_en` is 1, go to RUN and set `cnt_value` ← `cnt_load`.
- Tick is `(state==RUN|ARMED) & ~(stall & dbg_halt)`.
- Tick with `cnt_value`≠0: `cnt_value` decrements by 1 (32-bit, no wrap possible).
- Tick with `cnt_value`==0:
  - `cnt_value` ← `cnt_load`, and `value_eq0` ← 1 for one cycle.
  - From RUN, go to ARMED.
  - From ARMED with `resen`=0, stay in ARMED.
  - From ARMED with `resen`=1, `test`=0, go to RESET.
  - From ARMED with `resen`=1, `test`=1, set `test_reset` ← 1 and stay in ARMED.
- Load write (`wr_en & paddr[11:0]==12'h000 & ~lock`):
  - `cnt_load` ← `pwdata`, and `cnt_value` ← `pwdata` in any state.
  - Pending state is unchanged.
- Interrupt clear (`wr_en_icr`):
  - ARMED goes to RUN, with `cnt_value` ← `cnt_load`.
  - `test_reset` ← 0.
  - No effect in IDLE or RESET.
- RESET: `wdt_rst`=1 for exactly `RST_CYCLES` cycles, then go to RUN with `cnt_value` ← `cnt_load`. A system reset normally intervenes first.
- Priority in one cycle: `preset` > load write > `wr_en_icr` > tick.
  - A suppressed tick produces no `value_eq0` and no state change.
  - Load write and `wr_en_icr` together: both take effect. The state clears to RUN and `cnt_value` ← `pwdata`.
- `cnt_load`=0: a timeout fires on every tick. The second timeout escalates on the next cycle.
- Writes while locked are ignored. A write to address 0x000 while locked leaves both `cnt_load` and `cnt_value` untouched.

## Timing
- Reset values:
  - `cnt_load`=`cnt_value`=`LOAD_RST`.
  - `value_eq0`=`test_reset`=`wdt_rst`=0.
  - State is IDLE, and the RESET-phase counter is 0.
- All outputs are registered; there is no combinational path from input to output.
- `int_en` rising at edge N: `cnt_value`=`cnt_load` after N+1, and the first decrement is visible after N+2.
- Load write at edge N: new `cnt_load`/`cnt_value` is visible after N.
- Timeout: the tick at edge N with `cnt_value`==0 makes `value_eq0`=1 during cycle N..N+1 only. `cnt_value`=`cnt_load` in the same cycle.
- The period from load L to `value_eq0` is L+1 ticks.
- `wdt_rst` rises on the same edge as the second `value_eq0` and stays high for `RST_CYCLES` cycles.
- Stall: while `stall & dbg_halt`, `cnt_value` freezes exactly. Counting resumes on the first cycle the condition drops.
- `preset` mid-RESET drops `wdt_rst` at the next edge.

## Structure
- Shared package `wdt_pkg` holds:
  - the state enum `wdt_state_e` (IDLE, RUN, ARMED, RESET);
  - address constants `WDT_LOAD_ADDR`=12'h000, `WDT_VALUE_ADDR`=12'h004, `WDT_CTL_ADDR`=12'h008, `WDT_ICR_ADDR`=12'h00C, `WDT_TEST_ADDR`=12'h418, `WDT_LOCK_ADDR`=12'hC00;
  - `WDT_UNLOCK_KEY`=32'h1ACC_E551.
- The register bank and this block both import `wdt_pkg`.
- Single flat module; no sub-module is warranted. The RESET-phase counter is `$clog2(RST_CYCLES+1)` bits.

## Test plan
- Timeout sequence:
  - Stimulus: load 5, then `int_en`=1.
  - Required: `cnt_value` steps 5,4,3,2,1,0.
  - `value_eq0` pulses once, six ticks after the reload.
  - `cnt_value` returns to 5, and the state is ARMED.
- Second timeout with reset enabled:
  - Stimulus: load 3, `resen`=1, `test`=0, no ICR.
  - Required: the second `value_eq0` coincides with `wdt_rst`=1.
  - `wdt_rst` stays high for 4 cycles, then `cnt_value`=3.
- Interrupt clear before the second timeout:
  - Stimulus: `wr_en_icr` issued after the first timeout.
  - Required: no `wdt_rst`, `cnt_value` reloads to `cnt_load`, and the state returns to RUN.
- Test mode:
  - Stimulus: `test`=1, `resen`=1, two timeouts.
  - Required: `test_reset`=1 and held, `wdt_rst` stays 0.
  - `wr_en_icr` then clears `test_reset` to 0.
- Stall in debug:
  - Stimulus: `stall`=1, `dbg_halt`=1 for 10 cycles at `cnt_value`=100.
  - Required: `cnt_value` stays 100 throughout.
  - With `stall`=0, the same `dbg_halt` still decrements the counter.
- Collisions and lock:
  - Stimulus: load write of 7 and a zero tick in the same cycle.
  - Required: `cnt_value`=7 and no `value_eq0`.
  - Stimulus: `lock`=1 and a write of 0x55 to address 0x000.
  - Required: `cnt_load` is unchanged.
